mips_instr_encoder: RTL
=======================

// Module: mips_instr_encoder
// PURPOSE
//  Write-side counterpart of the single-cycle MIPS control decoder: takes instruction fields over a
//  valid/ready stream, packs them into 32-bit MIPS words, and writes them sequentially into instruction
//  memory. Sits between the testbench/UART loader and imem; covers every opcode the decoder recognises.
// PARAMETERS
//  ADDR_W  6   imem word-address width
//  DEPTH   64  max words per load session (<= 2**ADDR_W)
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   synchronous active-high reset
//  start       in   1   1-cycle pulse: begin a load session at word address 0
//  s_valid     in   1   instruction beat valid
//  s_ready     out  1   encoder can accept a beat
//  s_last      in   1   beat is final instruction of the program
//  s_kind      in   3   0 LW, 1 SW, 2 RTYPE, 3 ADDI, 4 BEQ, 5 J, 6/7 illegal
//  s_rs        in   5   source register
//  s_rt        in   5   target register
//  s_rd        in   5   destination (RTYPE only)
//  s_funct     in   6   function code (RTYPE only)
//  s_imm       in   16  immediate/offset (LW, SW, ADDI, BEQ)
//  s_target    in   26  jump target (J only)
//  imem_we     out  1   instruction-memory write strobe
//  imem_addr   out  ADDR_W  word address of write
//  imem_wdata  out  32  encoded instruction
//  count       out  ADDR_W+1  words written this session
//  done        out  1   session finished (level, until next start)
//  err         out  1   sticky: illegal s_kind seen this session
// BEHAVIOUR
//  Reset: state IDLE; s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, count=0, done=0, err=0.
//  FSM IDLE -> LOAD on start; LOAD -> FLUSH on accepted s_last beat or when accepted beat makes count
//   reach DEPTH; FLUSH -> DONE after the pending write issues (1 cycle); DONE -> LOAD on start.
//  start (IDLE/DONE): imem_addr=0, count=0, done=0, err=0. start in LOAD/FLUSH ignored.
//  s_ready = (state==LOAD) && (count_accepted < DEPTH). Beat accepted when s_valid && s_ready.
//  Latency 1: accepted beat in cycle N -> imem_we=1 with imem_wdata/imem_addr in cycle N+1;
//   imem_addr then increments, count increments in same cycle as strobe. Back-to-back beats give
//   back-to-back writes (full throughput).
//  Encoding (op[31:26]): LW 100011|rs|rt|imm; SW 101011|rs|rt|imm; ADDI 001000|rs|rt|imm;
//   BEQ 000100|rs|rt|imm; RTYPE 000000|rs|rt|rd|shamt=00000|funct; J 000010|target.
//   Unused fields of a beat are ignored, never leak into the word.
//  Illegal kind (6/7): beat accepted, no write, no address/count advance, err set; s_last on it still ends session.
//  Capacity: accepting the DEPTH-th beat ends session even without s_last; imem_addr never wraps.
//  done asserts the cycle after the final write (FLUSH->DONE); imem_we=0 in IDLE/DONE.
//  rst mid-session: aborts immediately, pending write dropped, all outputs to reset values.
// TESTING
//  start; LW rs=16 rt=8 imm=4, s_last -> one cycle later imem_we=1, addr=0, wdata=0x8E080004; done next cycle, count=1.
//  Back-to-back SW(16,8,8), RTYPE(8,9,10,f=0x20), ADDI(0,8,5), BEQ(8,9,0xFFFE), J(0x10) last ->
//   writes addr0..4 on consecutive cycles: 0xAE080008, 0x01095020, 0x20080005, 0x1109FFFE, 0x08000010.
//  Beat kind=7 between two LWs -> err=1, LWs land at addr0 and addr1, count=2.
//  DEPTH=4 build, 6 beats offered no s_last -> 4 writes (addr0..3), s_ready low after 4th accept, done=1.
//  rst asserted the cycle a beat is accepted -> no imem_we next cycle, all outputs 0; new start loads from addr0.
//  s_valid held with s_ready low (IDLE/DONE) -> no writes; start in LOAD -> ignored, addr continues.

Source files
------------

// File: rtl/mips_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips_instr_encoder
// Brief    : Packs instruction-field beats into MIPS words and writes them
//            sequentially into instruction memory for one load session.
// Revision : 1.0 - initial release
// ============================================================================
module mips_instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    input  logic [2:0]        s_kind,
    input  logic [4:0]        s_rs,
    input  logic [4:0]        s_rt,
    input  logic [4:0]        s_rd,
    input  logic [5:0]        s_funct,
    input  logic [15:0]       s_imm,
    input  logic [25:0]       s_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_LOAD  = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_CNT_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_accept;
    logic              w_legal;
    logic              w_start_ok;
    logic              w_end;
    logic [ADDR_W:0]   w_count_inc;
    logic [31:0]       w_word;

    assign s_ready     = (r_state == c_ST_LOAD) && (r_count < c_DEPTH);
    assign w_accept    = s_valid && s_ready;
    assign w_legal     = (s_kind <= 3'd5);
    assign w_start_ok  = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_count_inc = r_count + c_CNT_ONE;
    // Illegal beats never advance the count, so only legal ones can fill capacity.
    assign w_end       = w_accept && (s_last || (w_legal && (w_count_inc == c_DEPTH)));

    always_comb begin
        w_word = 32'h0000_0000;
        case (s_kind)
            3'd0:    w_word = {6'b100011, s_rs, s_rt, s_imm};
            3'd1:    w_word = {6'b101011, s_rs, s_rt, s_imm};
            3'd2:    w_word = {6'b000000, s_rs, s_rt, s_rd, 5'b00000, s_funct};
            3'd3:    w_word = {6'b001000, s_rs, s_rt, s_imm};
            3'd4:    w_word = {6'b000100, s_rs, s_rt, s_imm};
            3'd5:    w_word = {6'b000010, s_target};
            default: w_word = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (start) w_state_next = c_ST_LOAD;
            c_ST_LOAD:  if (w_end) w_state_next = c_ST_FLUSH;
            c_ST_FLUSH: w_state_next = c_ST_DONE;
            c_ST_DONE:  if (start) w_state_next = c_ST_LOAD;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= 32'h0000_0000;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_start_ok) begin
                r_addr  <= '0;
                r_count <= '0;
                r_err   <= 1'b0;
            end
            if (w_accept) begin
                if (w_legal) begin
                    r_we    <= 1'b1;
                    r_wdata <= w_word;
                    r_count <= w_count_inc;
                end else begin
                    r_err <= 1'b1;
                end
            end
            // Address advances once the strobe for it has been presented; saturates at the end.
            if (r_we && (r_addr != c_LAST_ADDR)) begin
                r_addr <= r_addr + c_ADDR_ONE;
            end
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign done       = (r_state == c_ST_DONE);
    assign err        = r_err;

endmodule
`default_nettype wire
